player_motion_fsm: RTL and testbench

- Parametrised successor to the dino player physics block. Holds signed vertical position and velocity, and runs an explicit jump state machine.
- Adds configurable widths and constants, variable jump height (early release cuts the rise), terminal-velocity saturation, a ceiling clamp, jump-input buffering while airborne, and a registered landing pulse.
- Sits between the input debouncer/controller and the renderer/collision logic. Advances only on the two-phase game tick: velocity phase, then position phase.

---
 rtl/player_pkg.sv | 26 ++
 rtl/player_motion_fsm_sat_add.sv | 30 +++
 rtl/player_motion_fsm.sv | 180 ++++++++++++++++++
 tb/tb_player_motion_fsm.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared types and default constants for the player motion block.
// Heights are signed with 0 at ground level and negative values above it.
package player_pkg;

    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        RISING   = 2'd1,
        FALLING  = 2'd2,
        FASTDROP = 2'd3
    } player_state_t;

    localparam int PLAYER_POS_W = 6;
    localparam int PLAYER_VEL_W = 4;
    localparam int JUMP_VEL     = -7;
    localparam int GRAVITY      = 1;
    localparam int FASTDROP_VEL = 6;

    // Bit positions within the two-phase game_tick bus.
    localparam int TICK_VEL = 0;
    localparam int TICK_POS = 1;

    function automatic bit fits_signed(input int value, input int width);
        return (value >= -(2 ** (width - 1))) && (value <= (2 ** (width - 1)) - 1);
    endfunction

endpackage

// File: rtl/player_motion_fsm_sat_add.sv
// Signed adder whose result is clamped to [MIN_VAL, MAX_VAL] instead of wrapping.
// Purely combinational; the sum is formed one bit wider so overflow is never lost.
module sat_add_signed #(
    parameter int W       = 4,
    parameter int MIN_VAL = -(2 ** (W - 1)),
    parameter int MAX_VAL = (2 ** (W - 1)) - 1
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] sum_o
);

    localparam logic signed [W:0] MIN_X = (W + 1)'(MIN_VAL);
    localparam logic signed [W:0] MAX_X = (W + 1)'(MAX_VAL);

    logic signed [W:0] wide;

    assign wide = {a_i[W-1], a_i} + {b_i[W-1], b_i};

    always_comb begin
        if (wide > MAX_X) begin
            sum_o = MAX_X[W-1:0];
        end else if (wide < MIN_X) begin
            sum_o = MIN_X[W-1:0];
        end else begin
            sum_o = wide[W-1:0];
        end
    end

endmodule

// File: rtl/player_motion_fsm.sv
// Player vertical physics: jump FSM, saturated velocity, ceiling clamp, jump buffering.
// State advances only on game ticks; a tick with both phases set runs only the velocity phase.
module player_motion_fsm #(
    parameter int POS_W          = player_pkg::PLAYER_POS_W,
    parameter int VEL_W          = player_pkg::PLAYER_VEL_W,
    parameter int JUMP_VEL       = player_pkg::JUMP_VEL,
    parameter int GRAVITY        = player_pkg::GRAVITY,
    parameter int FASTDROP_VEL   = player_pkg::FASTDROP_VEL,
    parameter int MAX_FALL_VEL   = 6,
    parameter int JUMP_CUT_VEL   = -2,
    parameter int MIN_POS        = -31,
    parameter int JUMP_BUF_TICKS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              game_tick,
    input  logic                    jump_req,
    input  logic                    jump_held,
    input  logic                    button_down,
    output logic signed [POS_W-1:0] position,
    output logic signed [VEL_W-1:0] velocity,
    output logic [1:0]              state,
    output logic                    airborne,
    output logic                    ducking,
    output logic                    land_pulse
);

    import player_pkg::*;

    localparam bit PARAMS_OK = fits_signed(JUMP_VEL, VEL_W) && fits_signed(GRAVITY, VEL_W)
                            && fits_signed(FASTDROP_VEL, VEL_W) && fits_signed(MAX_FALL_VEL, VEL_W)
                            && fits_signed(JUMP_CUT_VEL, VEL_W) && fits_signed(MIN_POS, POS_W)
                            && (MIN_POS <= 0) && (POS_W >= VEL_W) && (JUMP_BUF_TICKS >= 1);

    if (!PARAMS_OK) begin : g_param_check
        $error("player_motion_fsm: a constant does not fit its POS_W/VEL_W width");
    end

    localparam int BUF_W = (JUMP_BUF_TICKS < 2) ? 1 : $clog2(JUMP_BUF_TICKS + 1);

    localparam logic signed [VEL_W-1:0] JUMP_V     = VEL_W'(JUMP_VEL);
    localparam logic signed [VEL_W-1:0] GRAV_V     = VEL_W'(GRAVITY);
    localparam logic signed [VEL_W-1:0] FASTDROP_V = VEL_W'(FASTDROP_VEL);
    localparam logic signed [VEL_W-1:0] CUT_V      = VEL_W'(JUMP_CUT_VEL);
    localparam logic signed [POS_W-1:0] MIN_P      = POS_W'(MIN_POS);
    localparam logic signed [POS_W:0]   MIN_PX     = (POS_W + 1)'(MIN_POS);
    localparam logic [BUF_W-1:0]        BUF_LOAD   = BUF_W'(JUMP_BUF_TICKS);

    logic signed [POS_W-1:0] pos_q, pos_d;
    logic signed [VEL_W-1:0] vel_q, vel_d;
    player_state_t           state_q, state_d;
    logic [BUF_W-1:0]        buf_q, buf_d;
    logic                    duck_q, duck_d;
    logic                    land_q, land_d;

    logic signed [VEL_W-1:0] vel_grav;
    logic signed [VEL_W-1:0] rise_vel;
    logic signed [POS_W:0]   pos_sum;
    logic                    pending;
    logic                    jump_take;

    sat_add_signed #(
        .W       (VEL_W),
        .MIN_VAL (-(2 ** (VEL_W - 1))),
        .MAX_VAL (MAX_FALL_VEL)
    ) u_vel_add (
        .a_i   (vel_q),
        .b_i   (GRAV_V),
        .sum_o (vel_grav)
    );

    // Position path is deliberately unsaturated: the extra bit lets landing and ceiling be detected.
    assign pos_sum  = {pos_q[POS_W-1], pos_q} + {{(POS_W + 1 - VEL_W){vel_q[VEL_W-1]}}, vel_q};
    assign pending  = (buf_q != '0);
    assign rise_vel = (!jump_held && (vel_q < CUT_V)) ? CUT_V : vel_grav;

    always_comb begin
        pos_d     = pos_q;
        vel_d     = vel_q;
        state_d   = state_q;
        buf_d     = buf_q;
        duck_d    = duck_q;
        land_d    = 1'b0;
        jump_take = 1'b0;

        if (game_tick[TICK_VEL]) begin
            duck_d = (state_q == GROUNDED) && button_down;
            case (state_q)
                GROUNDED: begin
                    if (pending && !button_down) begin
                        vel_d     = JUMP_V;
                        state_d   = RISING;
                        jump_take = 1'b1;
                    end else begin
                        vel_d = '0;
                    end
                end
                RISING: begin
                    if (button_down) begin
                        vel_d   = FASTDROP_V;
                        state_d = FASTDROP;
                    end else begin
                        vel_d = rise_vel;
                        if (!rise_vel[VEL_W-1]) begin
                            state_d = FALLING;
                        end
                    end
                end
                FALLING: begin
                    if (button_down) begin
                        vel_d   = FASTDROP_V;
                        state_d = FASTDROP;
                    end else begin
                        vel_d = vel_grav;
                    end
                end
                FASTDROP: begin
                    vel_d = FASTDROP_V;
                    if (!button_down) begin
                        state_d = FALLING;
                    end
                end
                default: begin
                    state_d = GROUNDED;
                end
            endcase
        end else if (game_tick[TICK_POS]) begin
            if (pending) begin
                buf_d = buf_q - BUF_W'(1);
            end
            if (state_q != GROUNDED) begin
                if (!pos_sum[POS_W]) begin
                    pos_d   = '0;
                    vel_d   = '0;
                    state_d = GROUNDED;
                    land_d  = 1'b1;
                end else if (pos_sum < MIN_PX) begin
                    pos_d   = MIN_P;
                    vel_d   = '0;
                    state_d = FALLING;
                end else begin
                    pos_d = pos_sum[POS_W-1:0];
                end
            end
        end

        // A fresh request outranks both the clear-on-take and the tick decrement.
        if (jump_req) begin
            buf_d = BUF_LOAD;
        end else if (jump_take) begin
            buf_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q   <= '0;
            vel_q   <= '0;
            state_q <= GROUNDED;
            buf_q   <= '0;
            duck_q  <= 1'b0;
            land_q  <= 1'b0;
        end else begin
            pos_q   <= pos_d;
            vel_q   <= vel_d;
            state_q <= state_d;
            buf_q   <= buf_d;
            duck_q  <= duck_d;
            land_q  <= land_d;
        end
    end

    assign position   = pos_q;
    assign velocity   = vel_q;
    assign state      = state_q;
    assign airborne   = (state_q != GROUNDED);
    assign ducking    = duck_q;
    assign land_pulse = land_q;

endmodule

// File: tb/tb_player_motion_fsm.sv
// Scoreboard bench: the driver queues hand-computed expectations per tick, a monitor compares.
// Two instances share stimulus; the second uses a stronger jump and a low ceiling.
module tb_player_motion_fsm;

    localparam logic [1:0] S_G = 2'd0;
    localparam logic [1:0] S_R = 2'd1;
    localparam logic [1:0] S_F = 2'd2;
    localparam logic [1:0] S_D = 2'd3;
    localparam logic [1:0] TN  = 2'b00;
    localparam logic [1:0] TV  = 2'b01;
    localparam logic [1:0] TP  = 2'b10;
    localparam logic [1:0] TB  = 2'b11;

    typedef struct packed {
        logic       sel;
        logic [5:0] pos;
        logic [3:0] vel;
        logic [1:0] st;
        logic       land;
        logic       duck;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [1:0] game_tick;
    logic jump_req, jump_held, button_down;
    logic chk_req = 1'b0;
    logic chk_lat = 1'b0;

    logic signed [5:0] pos0, pos1;
    logic signed [3:0] vel0, vel1;
    logic [1:0]        st0, st1;
    logic              air0, air1, duck0, duck1, lp0, lp1;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  e_mon, a_mon;
    string nm_mon;
    int    n_checks = 0;
    int    n_err    = 0;
    int    cur_p    = 0;

    int fj_v[16] = '{-7, -6, -5, -4, -3, -2, -1, 0, 1, 2, 3, 4, 5, 6, 6, 6};
    int fj_p[16] = '{-7, -13, -18, -22, -25, -27, -28, -28, -27, -25, -22, -18, -13, -7, -1, 0};

    always #5 clk = ~clk;

    player_motion_fsm u_dut (
        .clk(clk), .reset(reset), .game_tick(game_tick), .jump_req(jump_req),
        .jump_held(jump_held), .button_down(button_down), .position(pos0), .velocity(vel0),
        .state(st0), .airborne(air0), .ducking(duck0), .land_pulse(lp0)
    );

    player_motion_fsm #(.JUMP_VEL(-8), .MIN_POS(-20)) u_ceil (
        .clk(clk), .reset(reset), .game_tick(game_tick), .jump_req(jump_req),
        .jump_held(jump_held), .button_down(button_down), .position(pos1), .velocity(vel1),
        .state(st1), .airborne(air1), .ducking(duck1), .land_pulse(lp1)
    );

    always @(posedge clk) chk_lat <= chk_req;

    always @(negedge clk) begin
        if (chk_lat) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard_underflow: DUT output with no expected entry");
            end else begin
                e_mon  = exp_q.pop_front();
                nm_mon = name_q.pop_front();
                a_mon  = e_mon.sel ? {1'b1, pos1, vel1, st1, lp1, duck1}
                                   : {1'b0, pos0, vel0, st0, lp0, duck0};
                if (a_mon.sel ? (air1 !== (st1 != S_G)) : (air0 !== (st0 != S_G))) begin
                    n_err++;
                    $display("FAIL %s_airborne: airborne disagrees with state %0d", nm_mon, a_mon.st);
                end else if (a_mon !== e_mon) begin
                    n_err++;
                    $display("FAIL %s: got pos=%0d vel=%0d st=%0d land=%0b duck=%0b, expected pos=%0d vel=%0d st=%0d land=%0b duck=%0b",
                             nm_mon, $signed(a_mon.pos), $signed(a_mon.vel), a_mon.st, a_mon.land, a_mon.duck,
                             $signed(e_mon.pos), $signed(e_mon.vel), e_mon.st, e_mon.land, e_mon.duck);
                end
            end
        end
    end

    task automatic step(input logic rst, input logic [1:0] gt, input logic jr, input logic sel,
                        input int p, input int v, input logic [1:0] s, input logic lp,
                        input logic dk, input string nm);
        exp_t e;
        @(negedge clk);
        reset = rst; game_tick = gt; jump_req = jr; chk_req = 1'b1;
        e.sel = sel; e.pos = 6'(p); e.vel = 4'(v); e.st = s; e.land = lp; e.duck = dk;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        reset = 1'b0; game_tick = TN; jump_req = 1'b0; chk_req = 1'b0;
    endtask

    // One velocity tick then one position tick; p==0 means the position tick lands.
    task automatic vp(input logic [1:0] gt, input logic sel, input int v, input logic [1:0] sv,
                      input int p, input string nm);
        step(1'b0, gt, 1'b0, sel, cur_p, v, sv, 1'b0, 1'b0, {nm, "_vel"});
        if (p == 0) step(1'b0, TP, 1'b0, sel, 0, 0, S_G, 1'b1, 1'b0, {nm, "_land"});
        else        step(1'b0, TP, 1'b0, sel, p, v, sv, 1'b0, 1'b0, {nm, "_pos"});
        cur_p = p;
    endtask

    task automatic full_jump(input int from, input int upto, input string nm);
        for (int i = from; i <= upto; i++) begin
            vp(TV, 1'b0, fj_v[i], (i < 7) ? S_R : S_F, fj_p[i], nm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; game_tick = TN; jump_req = 1'b0; jump_held = 1'b1; button_down = 1'b0;
        repeat (2) @(negedge clk);
        step(1'b1, TN, 1'b0, 1'b0, 0, 0, S_G, 1'b0, 1'b0, "reset_state");

        // Full jump with the button held throughout.
        cur_p = 0;
        step(1'b0, TN, 1'b1, 1'b0, 0, 0, S_G, 1'b0, 1'b0, "full_req");
        full_jump(0, 15, "full");
        step(1'b0, TN, 1'b0, 1'b0, 0, 0, S_G, 1'b0, 1'b0, "land_pulse_clear");

        // Early release cuts the rise.
        cur_p = 0;
        step(1'b0, TN, 1'b1, 1'b0, 0, 0, S_G, 1'b0, 1'b0, "cut_req");
        vp(TV, 1'b0, -7, S_R, -7, "cut_start");
        jump_held = 1'b0;
        vp(TV, 1'b0, -2, S_R, -9, "cut_a");
        vp(TV, 1'b0, -1, S_R, -10, "cut_b");
        vp(TV, 1'b0, 0, S_F, -10, "cut_apex");
        vp(TV, 1'b0, 1, S_F, -9, "cut_f1");
        vp(TV, 1'b0, 2, S_F, -7, "cut_f2");
        vp(TV, 1'b0, 3, S_F, -4, "cut_f3");
        vp(TV, 1'b0, 4, S_F, 0, "cut_f4");
        jump_held = 1'b1;

        // Fast drop from the rise.
        cur_p = 0;
        step(1'b0, TN, 1'b1, 1'b0, 0, 0, S_G, 1'b0, 1'b0, "fd_req");
        full_jump(0, 3, "fd_rise");
        button_down = 1'b1;
        vp(TV, 1'b0, 6, S_D, -16, "fd_a");
        vp(TV, 1'b0, 6, S_D, -10, "fd_b");
        vp(TV, 1'b0, 6, S_D, -4, "fd_c");
        vp(TV, 1'b0, 6, S_D, 0, "fd_land");

        // Down beats a pending jump; the buffer then expires over three position ticks.
        step(1'b0, TN, 1'b1, 1'b0, 0, 0, S_G, 1'b0, 1'b0, "prio_req");
        step(1'b0, TV, 1'b0, 1'b0, 0, 0, S_G, 1'b0, 1'b1, "prio_duck");
        for (int i = 0; i < 3; i++) step(1'b0, TP, 1'b0, 1'b0, 0, 0, S_G, 1'b0, 1'b1, "prio_drain");
        button_down = 1'b0;
        step(1'b0, TV, 1'b0, 1'b0, 0, 0, S_G, 1'b0, 1'b0, "prio_expired");

        // Buffered jump during the fall fires right after landing; also a dual-phase tick.
        cur_p = 0;
        step(1'b0, TN, 1'b1, 1'b0, 0, 0, S_G, 1'b0, 1'b0, "buf_req0");
        full_jump(0, 13, "buf_fall");
        step(1'b0, TN, 1'b1, 1'b0, -7, 6, S_F, 1'b0, 1'b0, "buf_req_air");
        vp(TV, 1'b0, 6, S_F, -1, "buf_a");
        vp(TV, 1'b0, 6, S_F, 0, "buf_land");
        vp(TV, 1'b0, -7, S_R, -7, "buf_fire");
        step(1'b0, TB, 1'b0, 1'b0, -7, -6, S_R, 1'b0, 1'b0, "both_ticks");
        step(1'b0, TP, 1'b0, 1'b0, -13, -6, S_R, 1'b0, 1'b0, "both_then_pos");
        cur_p = -13;
        full_jump(2, 15, "buf_rest");

        // Request four position ticks before landing is dropped.
        cur_p = 0;
        step(1'b0, TN, 1'b1, 1'b0, 0, 0, S_G, 1'b0, 1'b0, "drop_req0");
        full_jump(0, 11, "drop_fall");
        step(1'b0, TN, 1'b1, 1'b0, -18, 4, S_F, 1'b0, 1'b0, "drop_req_air");
        vp(TV, 1'b0, 5, S_F, -13, "drop_a");
        vp(TV, 1'b0, 6, S_F, -7, "drop_b");
        vp(TV, 1'b0, 6, S_F, -1, "drop_c");
        vp(TV, 1'b0, 6, S_F, 0, "drop_land");
        step(1'b0, TV, 1'b0, 1'b0, 0, 0, S_G, 1'b0, 1'b0, "drop_no_jump");

        // Reset mid-air with a pending request.
        cur_p = 0;
        step(1'b0, TN, 1'b1, 1'b0, 0, 0, S_G, 1'b0, 1'b0, "rst_req0");
        full_jump(0, 2, "rst_rise");
        step(1'b0, TN, 1'b1, 1'b0, -18, -5, S_R, 1'b0, 1'b0, "rst_req_air");
        step(1'b1, TV, 1'b0, 1'b0, 0, 0, S_G, 1'b0, 1'b0, "rst_midair");
        step(1'b0, TV, 1'b0, 1'b0, 0, 0, S_G, 1'b0, 1'b0, "rst_buf_cleared");

        // Ceiling clamp on the JUMP_VEL=-8 / MIN_POS=-20 instance.
        cur_p = 0;
        step(1'b0, TN, 1'b1, 1'b1, 0, 0, S_G, 1'b0, 1'b0, "ceil_req");
        vp(TV, 1'b1, -8, S_R, -8, "ceil_a");
        vp(TV, 1'b1, -7, S_R, -15, "ceil_b");
        step(1'b0, TV, 1'b0, 1'b1, -15, -6, S_R, 1'b0, 1'b0, "ceil_vel");
        step(1'b0, TP, 1'b0, 1'b1, -20, 0, S_F, 1'b0, 1'b0, "ceil_clamp");
        step(1'b0, TV, 1'b0, 1'b1, -20, 1, S_F, 1'b0, 1'b0, "ceil_fall_vel");
        step(1'b0, TP, 1'b0, 1'b1, -19, 1, S_F, 1'b0, 1'b0, "ceil_fall_pos");

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
